engagement_sequencer: RTL and testbench
=======================================

// Module: engagement_sequencer
// PURPOSE
//  Sequences the turret: arbitrates the three phototransistor requesters (forward/left/right),
//  drives the aim and release servo pulse-width commands (consumed by the PWM generator),
//  holds the rover while engaging, and tracks the 6-band magazine. Sits between the sensor
//  decoders and the servo PWM channels; one engagement = aim, settle, fire, cooldown, rearm.
// PARAMETERS
//  AIM_LEFT        5000         aim width offset, full left
//  AIM_RIGHT       200000       aim width offset, full right
//  AIM_FORWARD     100000       aim width offset, centre (idle/home)
//  SETTLE_CYCLES   50000000     aim-servo settle time before release (clock cycles)
//  FIRE_CYCLES     100000       release-servo hold time per shot
//  COOLDOWN_CYCLES 100000000    dead time after a shot before rearm
//  MAG_SIZE        6            bands per magazine (1..15)
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  forward_signal in   2   front sensor code; 2'b10 = new enemy
//  left_signal    in   2   left sensor code; 2'b10 = new enemy
//  right_signal   in   2   right sensor code; 2'b10 = new enemy
//  reload         in   1   1-cycle pulse: magazine refilled
//  aim_width      out  18  aim servo pulse-width offset (added to 70000 base by PWM)
//  fire_width     out  18  release servo pulse-width offset
//  rover_hold     out  1   1 = stop rover drive
//  fire_done      out  1   1-cycle pulse at end of each shot
//  empty          out  1   magazine exhausted
//  shots_left     out  4   MAG_SIZE - shots fired
//  state          out  3   current FSM state (debug)
// BEHAVIOUR
//  Reset (sync, next edge, any state): IDLE, aim_width=AIM_FORWARD, fire_width=0, rover_hold=0,
//   fire_done=0, empty=0, shots_left=MAG_SIZE, timer=0.
//  req_x = (x_signal == 2'b10). Priority forward > left > right; evaluated only in IDLE.
//  IDLE: no req or empty -> stay. Winner captured; rover_hold<=1; aim_width<=AIM_<winner>.
//   forward winner -> FIRE directly (aim already home); left/right -> SETTLE, timer<=SETTLE_CYCLES-1.
//  SETTLE: timer decrements; at 0 -> FIRE. Inputs ignored.
//  FIRE: entry cycle loads fire_width <= release_pos(shot index), timer<=FIRE_CYCLES-1;
//   release_pos: shots 0-1 -> 36000, 2-3 -> 70000, 4+ -> 120000 (saturate). At timer 0:
//   fire_done=1 for one cycle, shots_left-1, -> COOLDOWN.
//  COOLDOWN: entry sets rover_hold=0, aim_width=AIM_FORWARD, timer<=COOLDOWN_CYCLES-1.
//   At 0: shots_left==0 -> EMPTY, else -> REARM.
//  REARM: wait until no req_x asserted (same target must clear) -> IDLE. Stays indefinitely.
//  EMPTY: empty=1, requests ignored, rover_hold=0. reload -> fire_width=0, shots_left=MAG_SIZE,
//   empty=0, -> IDLE next edge.
//  reload in IDLE: same refill, stays IDLE. reload in any other state: ignored.
//  Same-cycle req and reload in IDLE: reload wins; request re-evaluated next cycle.
//  Timer: 31-bit unsigned; parameters of 0 treated as 1 (minimum one cycle per state).
//  fire_width holds last release position between shots (positional release servo).
//  Latency: forward req -> fire_width update 2 edges; aim_width/rover_hold update 1 edge after req.
// CONFIGURATION
//  ENGAGE_ROUND_ROBIN_EN defined: left and right both requesting alternate winner (pointer flips
//   after each left/right engagement, reset value favours left); forward still highest.
//  Undefined: strict fixed priority forward > left > right.
// STRUCTURE
//  engagement_pkg: state encoding (IDLE,SETTLE,FIRE,COOLDOWN,REARM,EMPTY), SENSOR_NEW=2'b10,
//   release position constants and release_pos() function, target-select encoding.
//  Sub-module engagement_timer: loadable 31-bit down-counter with load/en/zero; one instance.
// TESTING (bench params: SETTLE=10, FIRE=5, COOLDOWN=20, MAG_SIZE=6)
//  left=2'b10 1 cycle -> aim_width=5000, rover_hold=1, SETTLE 10 cyc, fire_width=36000, fire_done
//   after 5 cyc, aim_width back to 100000, rover_hold=0.
//  forward+left+right=2'b10 together -> forward wins, no SETTLE, aim_width stays 100000.
//  6 forward engagements -> fire_width 36000,36000,70000,70000,120000,120000; empty=1, 7th req
//   ignored; reload -> fire_width=0, shots_left=6, IDLE.
//  Hold right=2'b10 through COOLDOWN -> stays REARM; drop to 2'b00 -> IDLE, no second shot.
//  reset asserted mid-SETTLE -> next edge all outputs at reset values, state=IDLE.
//  ENGAGE_ROUND_ROBIN_EN: left+right held, repeated engagements -> aim 5000,200000,5000,...

Source files
------------

// File: rtl/engagement_pkg.sv
// Shared types and constants for the turret engagement sequencer: state and target encodings,
// sensor code, release servo positions and timer helpers.
package engagement_pkg;

  localparam int unsigned TIMER_WIDTH = 31;

  localparam logic [1:0] SENSOR_NEW = 2'b10;

  localparam logic [17:0] RELEASE_LOW  = 18'd36000;
  localparam logic [17:0] RELEASE_MID  = 18'd70000;
  localparam logic [17:0] RELEASE_HIGH = 18'd120000;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSettle   = 3'd1,
    StFire     = 3'd2,
    StCooldown = 3'd3,
    StRearm    = 3'd4,
    StEmpty    = 3'd5
  } engage_state_e;

  typedef enum logic [1:0] {
    TgtNone    = 2'd0,
    TgtForward = 2'd1,
    TgtLeft    = 2'd2,
    TgtRight   = 2'd3
  } target_e;

  // Release servo walks outward as the magazine drains; saturates at the last band position.
  function automatic logic [17:0] release_pos(input logic [3:0] shot_idx);
    if (shot_idx < 4'd2) begin
      return RELEASE_LOW;
    end else if (shot_idx < 4'd4) begin
      return RELEASE_MID;
    end else begin
      return RELEASE_HIGH;
    end
  endfunction

  // A duration of 0 still spends one cycle in the state.
  function automatic logic [TIMER_WIDTH-1:0] cycles_to_load(input int unsigned cycles);
    if (cycles == 0) begin
      return '0;
    end else begin
      return TIMER_WIDTH'(cycles - 1);
    end
  endfunction

endpackage

// File: rtl/engagement_sequencer_if.sv
// Sensor/reload inputs and servo/status outputs of the engagement sequencer.
interface engagement_sequencer_if;

  logic [1:0]  forward_signal;
  logic [1:0]  left_signal;
  logic [1:0]  right_signal;
  logic        reload;
  logic [17:0] aim_width;
  logic [17:0] fire_width;
  logic        rover_hold;
  logic        fire_done;
  logic        empty;
  logic [3:0]  shots_left;
  logic [2:0]  state;

  modport master (
    output forward_signal, left_signal, right_signal, reload,
    input  aim_width, fire_width, rover_hold, fire_done, empty, shots_left, state
  );

  modport slave (
    input  forward_signal, left_signal, right_signal, reload,
    output aim_width, fire_width, rover_hold, fire_done, empty, shots_left, state
  );

endinterface

// File: rtl/engagement_timer.sv
// Loadable down-counter that stops at zero; load takes priority over decrement.
module engagement_timer #(
  parameter int unsigned WIDTH = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/engagement_sequencer.sv
// Turret engagement sequencer: arbitrates sensor requests, aims, fires, cools down, tracks the
// magazine. Define ENGAGE_ROUND_ROBIN_EN to alternate left/right when both request together.
module engagement_sequencer
  import engagement_pkg::*;
#(
  parameter int unsigned AIM_LEFT        = 5000,
  parameter int unsigned AIM_RIGHT       = 200000,
  parameter int unsigned AIM_FORWARD     = 100000,
  parameter int unsigned SETTLE_CYCLES   = 50000000,
  parameter int unsigned FIRE_CYCLES     = 100000,
  parameter int unsigned COOLDOWN_CYCLES = 100000000,
  parameter int unsigned MAG_SIZE        = 6
) (
  input logic                   clock,
  input logic                   reset,
  engagement_sequencer_if.slave bus
);

  localparam logic [17:0] AimLeft    = 18'(AIM_LEFT);
  localparam logic [17:0] AimRight   = 18'(AIM_RIGHT);
  localparam logic [17:0] AimForward = 18'(AIM_FORWARD);
  localparam logic [3:0]  MagFull    = 4'(MAG_SIZE);

  engage_state_e state_q, state_d;
  target_e       winner;

  logic [17:0] aim_width_q, aim_width_d;
  logic [17:0] fire_width_q, fire_width_d;
  logic        rover_hold_q, rover_hold_d;
  logic        fire_done_q, fire_done_d;
  logic        empty_q, empty_d;
  logic [3:0]  shots_left_q, shots_left_d;
  logic        fire_entry_q, fire_entry_d;

  logic                   timer_load, timer_en, timer_zero;
  logic [TIMER_WIDTH-1:0] timer_load_value;

  logic req_forward, req_left, req_right, any_req, can_engage;
  logic [3:0] shot_idx;

  assign req_forward = (bus.forward_signal == SENSOR_NEW);
  assign req_left    = (bus.left_signal == SENSOR_NEW);
  assign req_right   = (bus.right_signal == SENSOR_NEW);
  assign any_req     = req_forward | req_left | req_right;
  assign can_engage  = !bus.reload && (shots_left_q != 4'd0) && (winner != TgtNone);
  assign shot_idx    = MagFull - shots_left_q;

`ifdef ENGAGE_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;  // 0: left favoured on a tie, 1: right favoured

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == StIdle) && can_engage && (winner != TgtForward)) begin
      rr_ptr_d = (winner == TgtLeft);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    winner = TgtNone;
    if (req_forward) begin
      winner = TgtForward;
    end else if (req_left && req_right) begin
`ifdef ENGAGE_ROUND_ROBIN_EN
      winner = rr_ptr_q ? TgtRight : TgtLeft;
`else
      winner = TgtLeft;
`endif
    end else if (req_left) begin
      winner = TgtLeft;
    end else if (req_right) begin
      winner = TgtRight;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      aim_width_q  <= AimForward;
      fire_width_q <= '0;
      rover_hold_q <= 1'b0;
      fire_done_q  <= 1'b0;
      empty_q      <= 1'b0;
      shots_left_q <= MagFull;
      fire_entry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      aim_width_q  <= aim_width_d;
      fire_width_q <= fire_width_d;
      rover_hold_q <= rover_hold_d;
      fire_done_q  <= fire_done_d;
      empty_q      <= empty_d;
      shots_left_q <= shots_left_d;
      fire_entry_q <= fire_entry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (can_engage) state_d = (winner == TgtForward) ? StFire : StSettle;
      StSettle:   if (timer_zero) state_d = StFire;
      StFire:     if (!fire_entry_q && timer_zero) state_d = StCooldown;
      StCooldown: if (timer_zero) state_d = (shots_left_q == 4'd0) ? StEmpty : StRearm;
      StRearm:    if (!any_req) state_d = StIdle;
      StEmpty:    if (bus.reload) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    aim_width_d      = aim_width_q;
    fire_width_d     = fire_width_q;
    rover_hold_d     = rover_hold_q;
    fire_done_d      = 1'b0;
    empty_d          = empty_q;
    shots_left_d     = shots_left_q;
    fire_entry_d     = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_en         = (state_q == StSettle) || (state_q == StFire) || (state_q == StCooldown);
    unique case (state_q)
      StIdle: begin
        if (bus.reload) begin
          fire_width_d = '0;
          shots_left_d = MagFull;
          empty_d      = 1'b0;
        end else if (can_engage) begin
          rover_hold_d = 1'b1;
          unique case (winner)
            TgtLeft:  aim_width_d = AimLeft;
            TgtRight: aim_width_d = AimRight;
            default:  aim_width_d = AimForward;
          endcase
          if (winner == TgtForward) begin
            fire_entry_d = 1'b1;
          end else begin
            timer_load       = 1'b1;
            timer_load_value = cycles_to_load(SETTLE_CYCLES);
          end
        end
      end
      StSettle: fire_entry_d = timer_zero;
      StFire: begin
        // First FIRE cycle only arms the release servo; the shot completes when the hold expires.
        if (fire_entry_q) begin
          fire_width_d     = release_pos(shot_idx);
          timer_load       = 1'b1;
          timer_load_value = cycles_to_load(FIRE_CYCLES);
        end else if (timer_zero) begin
          fire_done_d      = 1'b1;
          shots_left_d     = shots_left_q - 4'd1;
          rover_hold_d     = 1'b0;
          aim_width_d      = AimForward;
          timer_load       = 1'b1;
          timer_load_value = cycles_to_load(COOLDOWN_CYCLES);
        end
      end
      StCooldown: if (timer_zero && (shots_left_q == 4'd0)) empty_d = 1'b1;
      StRearm: ;
      StEmpty: begin
        rover_hold_d = 1'b0;
        empty_d      = 1'b1;
        if (bus.reload) begin
          fire_width_d = '0;
          shots_left_d = MagFull;
          empty_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  engagement_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .en        (timer_en),
    .load_value(timer_load_value),
    .zero      (timer_zero)
  );

  assign bus.aim_width  = aim_width_q;
  assign bus.fire_width = fire_width_q;
  assign bus.rover_hold = rover_hold_q;
  assign bus.fire_done  = fire_done_q;
  assign bus.empty      = empty_q;
  assign bus.shots_left = shots_left_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_engagement_sequencer.sv
// Directed bench for engagement_sequencer with short timing parameters.
module tb_engagement_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  engagement_sequencer_if bus ();

  engagement_sequencer #(
    .AIM_LEFT       (5000),
    .AIM_RIGHT      (200000),
    .AIM_FORWARD    (100000),
    .SETTLE_CYCLES  (10),
    .FIRE_CYCLES    (5),
    .COOLDOWN_CYCLES(20),
    .MAG_SIZE       (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.state != 3'd0; i++) tick();
    check("idle_reached", 32'(bus.state), 0);
  endtask

  task automatic finish_cooldown(input int exp_shots);
    ticks(19);
    check("cooldown_hold", 32'(bus.state), 3);
    tick();
    if (exp_shots == 0) begin
      check("to_empty", 32'(bus.state), 5);
      check("empty_set", 32'(bus.empty), 1);
    end else begin
      check("to_rearm", 32'(bus.state), 4);
      tick();
      check("rearm_to_idle", 32'(bus.state), 0);
    end
  endtask

  task automatic forward_shot(input int exp_fw, input int exp_shots);
    bus.forward_signal = 2'b10;
    tick();
    bus.forward_signal = 2'b00;
    check("fwd_state_fire", 32'(bus.state), 2);
    check("fwd_aim", 32'(bus.aim_width), 100000);
    check("fwd_hold", 32'(bus.rover_hold), 1);
    tick();
    check("fwd_fire_width", 32'(bus.fire_width), 32'(exp_fw));
    ticks(4);
    check("fwd_done_low", 32'(bus.fire_done), 0);
    tick();
    check("fwd_done", 32'(bus.fire_done), 1);
    check("fwd_shots", 32'(bus.shots_left), 32'(exp_shots));
    finish_cooldown(exp_shots);
  endtask

  initial begin
    logic [31:0] exp_second_aim;
    reset = 1'b1;
    bus.forward_signal = 2'b00;
    bus.left_signal    = 2'b00;
    bus.right_signal   = 2'b00;
    bus.reload         = 1'b0;
    ticks(2);
    check("rst_state", 32'(bus.state), 0);
    check("rst_aim", 32'(bus.aim_width), 100000);
    check("rst_fire", 32'(bus.fire_width), 0);
    check("rst_hold", 32'(bus.rover_hold), 0);
    check("rst_done", 32'(bus.fire_done), 0);
    check("rst_empty", 32'(bus.empty), 0);
    check("rst_shots", 32'(bus.shots_left), 6);
    reset = 1'b0;

    // Left engagement with settle.
    bus.left_signal = 2'b10;
    tick();
    bus.left_signal = 2'b00;
    check("left_aim", 32'(bus.aim_width), 5000);
    check("left_hold", 32'(bus.rover_hold), 1);
    check("left_settle", 32'(bus.state), 1);
    ticks(9);
    check("left_settle_end", 32'(bus.state), 1);
    tick();
    check("left_fire", 32'(bus.state), 2);
    check("left_fw_latency", 32'(bus.fire_width), 0);
    tick();
    check("left_fw", 32'(bus.fire_width), 36000);
    ticks(4);
    check("left_done_low", 32'(bus.fire_done), 0);
    tick();
    check("left_done", 32'(bus.fire_done), 1);
    check("left_shots", 32'(bus.shots_left), 5);
    check("left_aim_home", 32'(bus.aim_width), 100000);
    check("left_release", 32'(bus.rover_hold), 0);
    tick();
    check("left_done_pulse", 32'(bus.fire_done), 0);
    ticks(18);
    check("left_cooldown", 32'(bus.state), 3);
    tick();
    check("left_rearm", 32'(bus.state), 4);
    tick();
    check("left_idle", 32'(bus.state), 0);

    // All three request: forward wins with no settle.
    bus.forward_signal = 2'b10;
    bus.left_signal    = 2'b10;
    bus.right_signal   = 2'b10;
    tick();
    bus.forward_signal = 2'b00;
    bus.left_signal    = 2'b00;
    bus.right_signal   = 2'b00;
    check("all_fire", 32'(bus.state), 2);
    check("all_aim", 32'(bus.aim_width), 100000);
    tick();
    check("all_fw", 32'(bus.fire_width), 36000);
    ticks(4);
    tick();
    check("all_done", 32'(bus.fire_done), 1);
    check("all_shots", 32'(bus.shots_left), 4);
    finish_cooldown(4);

    // Right held through cooldown; reload during settle ignored.
    bus.right_signal = 2'b10;
    tick();
    check("right_aim", 32'(bus.aim_width), 200000);
    check("right_settle", 32'(bus.state), 1);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    check("reload_ignored", 32'(bus.shots_left), 4);
    ticks(8);
    check("right_settle_end", 32'(bus.state), 1);
    tick();
    check("right_fire", 32'(bus.state), 2);
    tick();
    check("right_fw", 32'(bus.fire_width), 70000);
    ticks(5);
    check("right_done", 32'(bus.fire_done), 1);
    check("right_shots", 32'(bus.shots_left), 3);
    ticks(19);
    check("right_cooldown", 32'(bus.state), 3);
    tick();
    ticks(5);
    check("right_held_rearm", 32'(bus.state), 4);
    bus.right_signal = 2'b00;
    tick();
    check("right_clear_idle", 32'(bus.state), 0);
    tick();
    check("no_second_shot", 32'(bus.state), 0);
    check("no_second_shots", 32'(bus.shots_left), 3);

    forward_shot(70000, 2);
    forward_shot(120000, 1);
    forward_shot(120000, 0);

    // Empty magazine ignores requests until reload.
    bus.forward_signal = 2'b10;
    tick();
    bus.forward_signal = 2'b00;
    check("empty_ignore", 32'(bus.state), 5);
    check("empty_hold", 32'(bus.rover_hold), 0);
    check("empty_fw_held", 32'(bus.fire_width), 120000);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    check("reload_state", 32'(bus.state), 0);
    check("reload_fw", 32'(bus.fire_width), 0);
    check("reload_shots", 32'(bus.shots_left), 6);
    check("reload_empty", 32'(bus.empty), 0);

    // Reload beats a same-cycle request in IDLE.
    bus.forward_signal = 2'b10;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    check("reload_wins_state", 32'(bus.state), 0);
    check("reload_wins_hold", 32'(bus.rover_hold), 0);
    tick();
    bus.forward_signal = 2'b00;
    check("req_after_reload", 32'(bus.state), 2);
    tick();
    check("req_after_reload_fw", 32'(bus.fire_width), 36000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_fire_state", 32'(bus.state), 0);
    check("rst_fire_fw", 32'(bus.fire_width), 0);

    // Reset mid-settle.
    bus.left_signal = 2'b10;
    tick();
    bus.left_signal = 2'b00;
    ticks(3);
    check("mid_settle", 32'(bus.state), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", 32'(bus.state), 0);
    check("mid_rst_aim", 32'(bus.aim_width), 100000);
    check("mid_rst_hold", 32'(bus.rover_hold), 0);
    check("mid_rst_shots", 32'(bus.shots_left), 6);
    check("mid_rst_done", 32'(bus.fire_done), 0);
    check("mid_rst_empty", 32'(bus.empty), 0);

    // Left and right together: fixed priority or alternation.
`ifdef ENGAGE_ROUND_ROBIN_EN
    exp_second_aim = 200000;
`else
    exp_second_aim = 5000;
`endif
    bus.left_signal  = 2'b10;
    bus.right_signal = 2'b10;
    tick();
    bus.left_signal  = 2'b00;
    bus.right_signal = 2'b00;
    check("tie1_aim", 32'(bus.aim_width), 5000);
    wait_idle(100);
    bus.left_signal  = 2'b10;
    bus.right_signal = 2'b10;
    tick();
    bus.left_signal  = 2'b00;
    bus.right_signal = 2'b00;
    check("tie2_aim", 32'(bus.aim_width), exp_second_aim);
    wait_idle(100);
    bus.left_signal  = 2'b10;
    bus.right_signal = 2'b10;
    tick();
    bus.left_signal  = 2'b00;
    bus.right_signal = 2'b00;
    check("tie3_aim", 32'(bus.aim_width), 5000);
    wait_idle(100);
    check("tie_shots", 32'(bus.shots_left), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
